// File: rtl/tt_mux_seq_pkg.sv
// Shared types and constants for the row mux sequencer.
package tt_mux_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    PWR_UP = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/tt_mux_seq_slot.sv
// Per-slot gating: enable and power flops fed from next-state decode, inward data gated by enable.
module tt_mux_seq_slot #(
  parameter int N_I = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           slot_sel,
  input  logic           pwr_on,
  input  logic           act_on,
  input  logic [N_I-1:0] si_usr,
  output logic           um_ena,
  output logic           um_pg_en,
  output logic [N_I-1:0] um_iw
);

  logic ena_r;
  logic pg_en_r;

  // Registered slot controls, so the slot pins never see decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_r   <= 1'b0;
      pg_en_r <= 1'b0;
    end else begin
      ena_r   <= slot_sel & act_on;
      pg_en_r <= slot_sel & pwr_on;
    end
  end

  // Inward data passes only while this slot is enabled.
  always_comb begin
    um_iw = {N_I{1'b0}};
    if (ena_r) begin
      um_iw = si_usr;
    end else begin
      um_iw = {N_I{1'b0}};
    end
  end

  assign um_ena   = ena_r;
  assign um_pg_en = pg_en_r;

endmodule

// File: rtl/tt_mux_seq.sv
// Row mux sequencer: decodes the spine select and walks the chosen slot through
// power-up, active and drain so that slot handover is power-safe.
module tt_mux_seq
  import tt_mux_seq_pkg::*;
#(
  parameter int N_UM      = 16,
  parameter int N_I       = 10,
  parameter int N_O       = 24,
  parameter int COL_W     = 5,
  parameter int PWR_CYC   = 8,
  parameter int GUARD_CYC = 4,
  parameter int OUT_REG   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           addr,
  input  logic                 sel_ena,
  input  logic [3:0]           sel_row,
  input  logic [COL_W-1:0]     sel_col,
  input  logic [N_I-1:0]       si_usr,
  output logic [N_O-1:0]       so_usr,
  input  logic [N_O*N_UM-1:0]  um_ow,
  output logic [N_I*N_UM-1:0]  um_iw,
  output logic [N_UM-1:0]      um_ena,
  output logic [N_UM-1:0]      um_pg_en,
  output logic                 busy,
  output logic                 k_zero
);

  localparam logic [CNT_W-1:0] PWR_INIT   = CNT_W'(PWR_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_INIT = CNT_W'(GUARD_CYC - 1);
  localparam logic [COL_W:0]   N_UM_C     = (COL_W + 1)'(N_UM);

  state_e           state_r, state_s;
  logic [COL_W-1:0] cur_r, cur_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             req_v_s;
  logic             same_s;
  logic [N_UM-1:0]  sel_s;
  logic [N_O-1:0]   ow_mux_s;
  logic             busy_r;

  assign req_v_s = sel_ena & (sel_row == addr) & ({1'b0, sel_col} < N_UM_C);
  assign same_s  = req_v_s & (sel_col == cur_r);

  // Handover FSM next-state; DRAIN only honours the request seen in its last cycle.
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    cnt_s   = cnt_r;
    case (state_r)
      OFF: begin
        if (req_v_s) begin
          cur_s   = sel_col;
          cnt_s   = PWR_INIT;
          state_s = PWR_UP;
        end else begin
          state_s = OFF;
        end
      end
      PWR_UP: begin
        if (!same_s) begin
          state_s = OFF;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ACTIVE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (!same_s) begin
          cnt_s   = GUARD_INIT;
          state_s = DRAIN;
        end else begin
          state_s = ACTIVE;
        end
      end
      DRAIN: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (req_v_s) begin
          cur_s   = sel_col;
          cnt_s   = PWR_INIT;
          state_s = PWR_UP;
        end else begin
          state_s = OFF;
        end
      end
      default: state_s = OFF;
    endcase
  end

  // FSM state, current column and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= OFF;
      cur_r   <= {COL_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cur_r   <= cur_s;
      cnt_r   <= cnt_s;
    end
  end

  // One-hot slot select and outward mux over the row.
  always_comb begin
    sel_s    = {N_UM{1'b0}};
    ow_mux_s = {N_O{1'b0}};
    for (int i = 0; i < N_UM; i++) begin
      sel_s[i] = (cur_s == COL_W'(i));
      ow_mux_s = ow_mux_s | ((cur_r == COL_W'(i)) ? um_ow[N_O*i +: N_O] : {N_O{1'b0}});
    end
  end

  for (genvar g = 0; g < N_UM; g++) begin : g_slot
    tt_mux_seq_slot #(.N_I(N_I)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .slot_sel (sel_s[g]),
      .pwr_on   (state_s != OFF),
      .act_on   (state_s == ACTIVE),
      .si_usr   (si_usr),
      .um_ena   (um_ena[g]),
      .um_pg_en (um_pg_en[g]),
      .um_iw    (um_iw[N_I*g +: N_I])
    );
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [N_O-1:0] so_q_r;
    // Outward data captured only when the next cycle is ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        so_q_r <= {N_O{1'b0}};
      end else begin
        so_q_r <= (state_s == ACTIVE) ? ow_mux_s : {N_O{1'b0}};
      end
    end
    assign so_usr = so_q_r;
  end else begin : g_ocomb
    assign so_usr = (state_r == ACTIVE) ? ow_mux_s : {N_O{1'b0}};
  end

  // Busy flag registered from the next state so it lines up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_s == PWR_UP) | (state_s == DRAIN);
    end
  end

  assign busy   = busy_r;
  assign k_zero = 1'b0;

endmodule

// File: tb/tb_tt_mux_seq.sv
// Directed bench for tt_mux_seq: power-up, handover, drain, gating and reset scenarios.
module tb_tt_mux_seq;

  localparam int N_UM  = 16;
  localparam int N_I   = 10;
  localparam int N_O   = 24;
  localparam int COL_W = 5;

  logic                clk;
  logic                rst_n;
  logic [3:0]          addr;
  logic                sel_ena;
  logic [3:0]          sel_row;
  logic [COL_W-1:0]    sel_col;
  logic [N_I-1:0]      si_usr;
  logic [N_O-1:0]      so_usr;
  logic [N_O*N_UM-1:0] um_ow;
  logic [N_I*N_UM-1:0] um_iw;
  logic [N_UM-1:0]     um_ena;
  logic [N_UM-1:0]     um_pg_en;
  logic                busy;
  logic                k_zero;

  int total = 0;
  int bad   = 0;

  logic [N_UM-1:0]     exp_pg, exp_ena;
  logic [N_O-1:0]      exp_so;
  logic [N_I*N_UM-1:0] exp_iw;
  logic                exp_busy;

  tt_mux_seq #(
    .N_UM(N_UM), .N_I(N_I), .N_O(N_O), .COL_W(COL_W),
    .PWR_CYC(8), .GUARD_CYC(4), .OUT_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .sel_ena(sel_ena),
    .sel_row(sel_row), .sel_col(sel_col), .si_usr(si_usr), .so_usr(so_usr),
    .um_ow(um_ow), .um_iw(um_iw), .um_ena(um_ena), .um_pg_en(um_pg_en),
    .busy(busy), .k_zero(k_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // At most one slot powered / enabled, every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ($countones(um_pg_en) > 1 || $countones(um_ena) > 1 || k_zero !== 1'b0) begin
        bad++;
        $display("FAIL onehot: pg_en=%h ena=%h k_zero=%b", um_pg_en, um_ena, k_zero);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr = 4'd3; sel_ena = 1'b0; sel_row = 4'd0; sel_col = 5'd0;
    si_usr = 10'h3FF;
    for (int i = 0; i < N_UM; i++)
      um_ow[N_O*i +: N_O] = (i == 5) ? 24'hA5A5A5 : {8'(i), 8'hC3, 8'(i)};
    #3;
    total++;
    if (um_ena !== 16'h0 || um_pg_en !== 16'h0 || um_iw !== '0 || so_usr !== 24'h0
        || busy !== 1'b0 || k_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset: ena=%h pg=%h iw=%h so=%h busy=%b want all 0",
               um_ena, um_pg_en, um_iw, so_usr, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    sel_ena = 1'b1; sel_row = 4'd3; sel_col = 5'd5; si_usr = 10'h155;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_pg   = 16'h0020;
      exp_ena  = (k == 9) ? 16'h0020 : 16'h0000;
      exp_so   = (k == 9) ? 24'hA5A5A5 : 24'h0;
      exp_busy = (k < 9);
      exp_iw   = '0;
      if (k == 9) exp_iw[N_I*5 +: N_I] = 10'h155;
      total++;
      if (um_pg_en !== exp_pg || um_ena !== exp_ena) begin
        bad++;
        $display("FAIL pwr_up k=%0d: pg=%h ena=%h want pg=%h ena=%h", k, um_pg_en, um_ena, exp_pg, exp_ena);
      end
      total++;
      if (so_usr !== exp_so || busy !== exp_busy || um_iw !== exp_iw) begin
        bad++;
        $display("FAIL pwr_up_data k=%0d: so=%h busy=%b iw=%h want so=%h busy=%b iw=%h",
                 k, so_usr, busy, um_iw, exp_so, exp_busy, exp_iw);
      end
    end
  endtask

  task automatic test_switch();
    sel_col = 5'd9;
    for (int k = 1; k <= 13; k++) begin
      step();
      exp_pg   = (k <= 4) ? 16'h0020 : 16'h0200;
      exp_ena  = (k == 13) ? 16'h0200 : 16'h0000;
      exp_so   = (k == 13) ? 24'h09C309 : 24'h0;
      exp_busy = (k <= 12);
      total++;
      if (um_pg_en !== exp_pg || um_ena !== exp_ena || so_usr !== exp_so || busy !== exp_busy) begin
        bad++;
        $display("FAIL switch k=%0d: pg=%h ena=%h so=%h busy=%b want pg=%h ena=%h so=%h busy=%b",
                 k, um_pg_en, um_ena, so_usr, busy, exp_pg, exp_ena, exp_so, exp_busy);
      end
    end
  endtask

  task automatic test_drain_ignore();
    sel_col = 5'd4;
    for (int k = 1; k <= 6; k++) begin
      sel_ena  = (k >= 2 && k <= 4);
      step();
      exp_pg   = (k <= 4) ? 16'h0200 : 16'h0000;
      exp_busy = (k <= 4);
      total++;
      if (um_pg_en !== exp_pg || um_ena !== 16'h0 || busy !== exp_busy || so_usr !== 24'h0) begin
        bad++;
        $display("FAIL drain_ignore k=%0d: pg=%h ena=%h busy=%b so=%h want pg=%h ena=0 busy=%b so=0",
                 k, um_pg_en, um_ena, busy, so_usr, exp_pg, exp_busy);
      end
    end
  endtask

  task automatic test_invalid();
    for (int v = 0; v < 3; v++) begin
      sel_ena = 1'b1;
      sel_row = (v == 0) ? 4'd2 : 4'd3;
      sel_col = (v == 0) ? 5'd5 : ((v == 1) ? 5'd20 : 5'd16);
      for (int k = 0; k < 3; k++) begin
        step();
        total++;
        if (um_pg_en !== 16'h0 || um_ena !== 16'h0 || busy !== 1'b0 || so_usr !== 24'h0 || um_iw !== '0) begin
          bad++;
          $display("FAIL invalid v=%0d k=%0d: pg=%h ena=%h busy=%b so=%h want all 0",
                   v, k, um_pg_en, um_ena, busy, so_usr);
        end
      end
    end
  endtask

  task automatic test_pwr_drop();
    sel_row = 4'd3; sel_col = 5'd7;
    for (int k = 1; k <= 5; k++) begin
      sel_ena  = (k <= 3);
      step();
      exp_pg   = (k <= 3) ? 16'h0080 : 16'h0000;
      exp_busy = (k <= 3);
      total++;
      if (um_pg_en !== exp_pg || um_ena !== 16'h0 || busy !== exp_busy) begin
        bad++;
        $display("FAIL pwr_drop k=%0d: pg=%h ena=%h busy=%b want pg=%h ena=0 busy=%b",
                 k, um_pg_en, um_ena, busy, exp_pg, exp_busy);
      end
    end
  endtask

  task automatic test_iw_gating();
    logic [N_I-1:0] si_v;
    logic [N_O-1:0] ow_v;
    sel_ena = 1'b1; sel_row = 4'd3; sel_col = 5'd0;
    repeat (9) step();
    total++;
    if (um_ena !== 16'h0001) begin
      bad++;
      $display("FAIL iw_enter: ena=%h want 0001", um_ena);
    end
    for (int k = 0; k < 8; k++) begin
      si_v = N_I'($urandom);
      ow_v = N_O'($urandom);
      si_usr = si_v;
      um_ow[0 +: N_O] = ow_v;
      step();
      exp_iw = '0;
      exp_iw[0 +: N_I] = si_v;
      total++;
      if (um_iw !== exp_iw || so_usr !== ow_v) begin
        bad++;
        $display("FAIL iw_gating k=%0d: iw=%h so=%h want iw=%h so=%h", k, um_iw, so_usr, exp_iw, ow_v);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    sel_ena = 1'b0;
    step();
    step();
    total++;
    if (busy !== 1'b1 || um_pg_en !== 16'h0001) begin
      bad++;
      $display("FAIL pre_reset_drain: busy=%b pg=%h want busy=1 pg=0001", busy, um_pg_en);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (um_ena !== 16'h0 || um_pg_en !== 16'h0 || um_iw !== '0 || so_usr !== 24'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ena=%h pg=%h so=%h busy=%b want all 0", um_ena, um_pg_en, so_usr, busy);
    end
    step();
    rst_n = 1'b1;
    sel_ena = 1'b1; sel_col = 5'd5;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_ena = (k == 9) ? 16'h0020 : 16'h0000;
      total++;
      if (um_ena !== exp_ena || um_pg_en !== 16'h0020) begin
        bad++;
        $display("FAIL post_reset k=%0d: ena=%h pg=%h want ena=%h pg=0020", k, um_ena, um_pg_en, exp_ena);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_switch();
    test_drain_ignore();
    test_invalid();
    test_pwr_drop();
    test_iw_gating();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
